// File: rtl/tnoc_pkg.sv
// Shared NoC definitions: flit width and flit type,
// common to the flit FIFO and the NoC BFM flit interface.
package tnoc_pkg;
  localparam int TNOC_FLIT_WIDTH = 32;
  typedef logic [TNOC_FLIT_WIDTH-1:0] tnoc_flit;
endpackage

// File: rtl/tnoc_flit_fifo_ram.sv
// Flit storage: synchronous write port, asynchronous read port.
// No reset on the array contents.
module tnoc_flit_fifo_ram #(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [FLIT_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [FLIT_WIDTH-1:0] o_rdata
);
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/tnoc_flit_fifo.sv
// Valid/ready flit FIFO with registered o_ready.
// Optional zero-latency bypass: define TNOC_FLIT_FIFO_BYPASS_EN.
module tnoc_flit_fifo
  import tnoc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = TNOC_FLIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [FLIT_WIDTH-1:0]    i_flit,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [FLIT_WIDTH-1:0]    o_flit,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ready;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_rd;
  logic [CW-1:0]         w_cnt_nxt;
  logic [FLIT_WIDTH-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef TNOC_FLIT_FIFO_BYPASS_EN
  assign w_bypass = w_empty & i_valid & r_ready;
  assign o_valid  = ~w_empty | w_bypass;
  assign o_flit   = w_bypass ? i_flit : w_rdata;
`else
  assign w_bypass = 1'b0;
  assign o_valid  = ~w_empty;
  assign o_flit   = w_rdata;
`endif

  assign w_push = i_valid & r_ready;
  assign w_pop  = o_valid & i_ready;
  // A bypassed flit that is taken at once never touches storage
  assign w_wr   = w_push & ~(w_bypass & i_ready);
  assign w_rd   = w_pop & ~w_bypass;

  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_wr, w_rd})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // o_ready is a register so it carries no path from i_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != FULL_CNT);
    end
  end

  tnoc_flit_fifo_ram #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (i_flit),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign o_ready = r_ready;
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
endmodule

// File: tb/tb_tnoc_flit_fifo.sv
// Bench for tnoc_flit_fifo: vector table, corner sequences,
// and random traffic against a queue reference model.
module tb_tnoc_flit_fifo;
  import tnoc_pkg::*;

  localparam int DEPTH = 4;

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  logic     i_valid = 1'b0;
  logic     i_ready = 1'b0;
  tnoc_flit i_flit = '0;
  logic     o_ready;
  logic     o_valid;
  tnoc_flit o_flit;
  logic [2:0] o_count;
  logic     o_empty;
  logic     o_full;

  int n_tests = 0;
  int n_fail  = 0;

  tnoc_flit q[$];
  bit       rdy = 0;

  typedef struct {
    logic       v;
    logic       r;
    tnoc_flit   f;
    logic [2:0] cnt;
    logic       full;
    logic       rdy;
    logic       vld;
    tnoc_flit   flit;
  } vec_t;

  vec_t vecs[$];

  tnoc_flit_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_flit  (i_flit),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_flit  (o_flit),
    .o_count (o_count),
    .o_empty (o_empty),
    .o_full  (o_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against model, clock, update model
  task automatic cyc(input logic v, input logic r, input tnoc_flit f);
    bit byp, ev, er, push, pop;
    tnoc_flit ef;
    i_valid = v; i_ready = r; i_flit = f;
    #1;
    byp = 0;
`ifdef TNOC_FLIT_FIFO_BYPASS_EN
    byp = (q.size() == 0) && v && rdy;
`endif
    er = rdy && (q.size() < DEPTH);
    ev = (q.size() > 0) || byp;
    ef = byp ? f : (q.size() > 0 ? q[0] : '0);
    chk("ready", o_ready, er);
    chk("valid", o_valid, ev);
    chk("count", o_count, q.size());
    chk("empty", o_empty, q.size() == 0);
    chk("full", o_full, q.size() == DEPTH);
    if (ev) chk("flit", o_flit, ef);
    push = v && er;
    pop  = ev && r;
    if (!(byp && r)) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(f);
    end
    @(posedge clk);
    rdy = 1;
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_count", o_count, 3'd0);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_full", o_full, 1'b0);
    q.delete();
    rdy = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic v, input logic r, input tnoc_flit f,
                     input logic [2:0] cnt, input logic full,
                     input logic rd, input logic vld, input tnoc_flit fl);
    vec_t e;
    e.v = v; e.r = r; e.f = f; e.cnt = cnt;
    e.full = full; e.rdy = rd; e.vld = vld; e.flit = fl;
    vecs.push_back(e);
  endtask

  initial begin
    add(1, 0, 32'h01, 1, 0, 1, 1, 32'h01);
    add(1, 0, 32'h02, 2, 0, 1, 1, 32'h01);
    add(1, 0, 32'h03, 3, 0, 1, 1, 32'h01);
    add(1, 0, 32'h04, 4, 1, 0, 1, 32'h01);
    add(1, 0, 32'h05, 4, 1, 0, 1, 32'h01);
    add(1, 0, 32'h06, 4, 1, 0, 1, 32'h01);
    add(0, 1, 32'h00, 3, 0, 1, 1, 32'h02);
    add(0, 1, 32'h00, 2, 0, 1, 1, 32'h03);
    add(0, 1, 32'h00, 1, 0, 1, 1, 32'h04);
    add(0, 1, 32'h00, 0, 0, 1, 0, 32'h00);
`ifndef TNOC_FLIT_FIFO_BYPASS_EN
    add(1, 1, 32'h11, 1, 0, 1, 1, 32'h11);
    add(1, 1, 32'h22, 1, 0, 1, 1, 32'h22);
    add(1, 1, 32'h33, 1, 0, 1, 1, 32'h33);
    add(0, 1, 32'h00, 0, 0, 1, 0, 32'h00);
`endif

    #2 rst = 1'b1;
    #1;
    chk("por_count", o_count, 3'd0);
    chk("por_empty", o_empty, 1'b1);
    chk("por_full", o_full, 1'b0);
    chk("por_valid", o_valid, 1'b0);
    chk("por_ready", o_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy = 0;
    cyc(0, 0, '0);
    chk("ready_after_rst", o_ready, 1'b1);

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].r, vecs[i].f);
      chk($sformatf("vec%0d_count", i), o_count, vecs[i].cnt);
      chk($sformatf("vec%0d_full", i), o_full, vecs[i].full);
      chk($sformatf("vec%0d_ready", i), o_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].vld);
      if (vecs[i].vld)
        chk($sformatf("vec%0d_flit", i), o_flit, vecs[i].flit);
    end

    // Full: pop frees a slot, o_ready returns next cycle, refill to 4
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h40 + i);
    chk("full_set", o_full, 1'b1);
    cyc(1, 1, 32'h99);
    chk("full_pop_count", o_count, 3'd3);
    chk("full_pop_ready", o_ready, 1'b1);
    chk("full_pop_head", o_flit, 32'h41);
    cyc(1, 0, 32'h44);
    chk("refill_count", o_count, 3'd4);
    chk("refill_full", o_full, 1'b1);
    for (int i = 0; i < 2; i++) cyc(0, 1, '0);

    // Steady push+pop at count 2, pointers wrap repeatedly
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 32'h100 + i);
      chk("steady_count", o_count, 3'd2);
    end
    for (int i = 0; i < 2; i++) cyc(0, 1, '0);

    // Reset mid-stream with three stored flits
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h70 + i);
    chk("pre_rst_count", o_count, 3'd3);
    rst_pulse();
    cyc(1, 0, 32'hAA);
    cyc(1, 0, 32'hAA);
    cyc(1, 0, 32'hBB);
    chk("post_rst_head", o_flit, 32'hAA);
    chk("post_rst_count", o_count, 3'd2);
    for (int i = 0; i < 3; i++) cyc(0, 1, '0);

`ifdef TNOC_FLIT_FIFO_BYPASS_EN
    i_valid = 1; i_ready = 1; i_flit = 32'h5A;
    #1;
    chk("byp_flit", o_flit, 32'h5A);
    chk("byp_valid", o_valid, 1'b1);
    cyc(1, 1, 32'h5A);
    chk("byp_count0", o_count, 3'd0);
    cyc(1, 0, 32'h5A);
    chk("byp_count1", o_count, 3'd1);
    cyc(0, 1, '0);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      int pv, pr;
      pv = (i / 100) % 2 ? 80 : 40;
      pr = (i / 100) % 2 ? 30 : 70;
      if ($urandom_range(0, 99) == 0) rst_pulse();
      cyc($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
          tnoc_flit'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
